// File: rtl/minterm_scanner_pkg.sv
// Shared types and default sizing for the minterm scanner.
// Holds the FSM state encoding and the helpers that size the truth table.
package minterm_scanner_pkg;

    localparam int N_VARS_DEF = 4;
    localparam int TBL_W      = 2 ** N_VARS_DEF;
    localparam int IDX_MAX    = TBL_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_e;

    function automatic int tbl_width(input int n_vars);
        return 1 << n_vars;
    endfunction

endpackage

// File: rtl/minterm_idx_counter.sv
// Scan index register with a terminal-count flag.
// Never wraps: an increment request at the last index is ignored.
module minterm_idx_counter
    import minterm_scanner_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [N_VARS-1:0] idx,
    output logic              at_max
);

    localparam logic [N_VARS-1:0] IDX_LAST = {N_VARS{1'b1}};
    localparam logic [N_VARS-1:0] IDX_ONE  = {{(N_VARS-1){1'b0}}, 1'b1};

    logic [N_VARS-1:0] idx_q;
    logic [N_VARS-1:0] idx_d;

    assign idx    = idx_q;
    assign at_max = (idx_q == IDX_LAST);

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc && !at_max) begin
            idx_d = idx_q + IDX_ONE;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/minterm_scanner.sv
// Walks a latched truth table from index 0 upward and streams every true index
// over valid/ready, counting the minterms and pulsing done at the end of the scan.
module minterm_scanner
    import minterm_scanner_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [tbl_width(N_VARS)-1:0]       table_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [N_VARS-1:0]                  out_index,
    output logic [N_VARS:0]                    minterm_count,
    output logic                               busy,
    output logic                               done
);

    localparam int             W       = tbl_width(N_VARS);
    localparam logic [N_VARS:0] CNT_ONE = {{N_VARS{1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [W-1:0]       tbl_q, tbl_d;
    logic               out_valid_q, out_valid_d;
    logic [N_VARS-1:0]  out_index_q, out_index_d;
    logic [N_VARS:0]    count_q, count_d;

    logic               idx_clr;
    logic               idx_inc;
    logic [N_VARS-1:0]  idx;
    logic               idx_at_max;

    minterm_idx_counter #(
        .N_VARS (N_VARS)
    ) u_idx_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (idx_clr),
        .inc    (idx_inc),
        .idx    (idx),
        .at_max (idx_at_max)
    );

    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        tbl_d       = tbl_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        count_d     = count_q;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tbl_d   = table_in;
                    count_d = '0;
                    idx_clr = 1'b1;
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (tbl_q[idx]) begin
                    out_index_d = idx;
                    out_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end else if (idx_at_max) begin
                    state_d = ST_DONE;
                end else begin
                    idx_inc = 1'b1;
                end
            end

            // out_valid and out_index stay frozen until the consumer takes the index.
            ST_EMIT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = count_q + CNT_ONE;
                    if (idx_at_max) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = ST_SCAN;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tbl_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            count_q     <= count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_index     = out_index_q;
    assign minterm_count = count_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

endmodule

// File: doc/minterm_scanner.md
Name: minterm_scanner

Overview:
- Sequential inverse of the team's combinational SOP evaluators: instead of computing f from (a,b,c,d), it takes f's truth table and recovers the input combinations (minterms) that make f = 1.
- Scans indices 0..2^N_VARS-1 in order.
- Streams each true index out over a valid/ready handshake, counts the minterms, and pulses done.
- Used as a bench/lab utility next to the SOP modules: derives the canonical sum-of-minterms from a truth-table vector.

Parameters:
- N_VARS, 4, number of Boolean inputs; table width is 2^N_VARS, index width is N_VARS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- table_in  in  2^N_VARS  truth table; bit i = f(index i); index MSB = first variable (a).
- out_valid  out  1  out_index holds a minterm.
- out_ready  in  1  consumer accepts out_index.
- out_index  out  N_VARS  current minterm index.
- minterm_count  out  N_VARS+1  minterms emitted in the current/last scan.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of scan.

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset (async, rst_n=0) forces:
  - state = IDLE, idx = 0, table register = 0.
  - out_valid = 0, out_index = 0, minterm_count = 0, busy = 0, done = 0.
- Reset mid-scan aborts immediately. Nothing further is emitted and no done pulse follows.
- States and transitions:
  - IDLE: if start=1 at an edge, latch table_in, set idx = 0, clear minterm_count, go to SCAN. Otherwise stay.
  - SCAN (1 cycle per index): if table[idx] = 1, load out_index = idx, set out_valid = 1, go to EMIT. If table[idx] = 0 and idx = max, go to DONE. If table[idx] = 0 and idx < max, idx++ and stay in SCAN.
  - EMIT: hold out_valid and out_index stable until out_valid & out_ready at an edge. On that handshake: out_valid = 0 and minterm_count++. Then go to DONE if idx = max; otherwise idx++ and go to SCAN.
  - DONE: done = 1 for exactly this one cycle, then go to IDLE. busy is high in DONE.
- out_valid is never dropped without a handshake. out_index never changes while out_valid = 1.
- start while busy is ignored. table_in is sampled only when start is accepted, so later changes have no effect.
- Latency, with start accepted at edge k:
  - Zero-bit index costs 1 cycle; true index costs 2 cycles with out_ready held high.
  - Table 0: 2^N_VARS SCAN cycles, done high in cycle k+2^N_VARS+1, count = 0.
  - Table all ones, out_ready=1: 2·2^N_VARS cycles before DONE.
- Wrap-around: idx never wraps. Termination uses the idx = max compare. minterm_count saturates naturally at 2^N_VARS (hence the +1 width).
- minterm_count and out_index hold their last values in IDLE until the next accepted start.
- Simultaneous start and done: start in DONE is ignored. start in the cycle after DONE (IDLE) is accepted.

Decomposition:
- Shared package (e.g. logic_lab_pkg) holds:
  - state enum {IDLE, SCAN, EMIT, DONE};
  - localparams TBL_W = 2**N_VARS, IDX_MAX = TBL_W-1.
- No sub-module needed. The optional scan counter with terminal-count flag may be split out as minterm_idx_counter.

Test Plan:
- Lab SOP f = bc'd' + a'b'cd' + ab'cd + a'bcd, table_in = 16'h1894, out_ready=1 -> out_index sequence 2,4,7,11,12; minterm_count = 5; single done pulse; busy low after.
- table_in = 16'h0000 -> no out_valid ever; done exactly 17 cycles after the start edge; count = 0.
- table_in = 16'hFFFF, out_ready=1 -> indices 0..15 in order, count = 16 (5'b10000); done 33 cycles after start.
- table_in = 16'h8001, out_ready held low 5 cycles on index 0 -> out_valid/out_index=0 stable for all 5 cycles; then index 15 emitted; count = 2.
- Mid-scan: start with 16'h1894, pulse start again and change table_in during EMIT -> both ignored; sequence unchanged.
- rst_n low during EMIT of index 7 -> all outputs 0 asynchronously. After release, no done pulse; a new start with 16'h0010 yields only index 4.
